// File: rtl/serializer.sv
// ----------------------------------------------------------------------------
// serializer
//
// Parallel-to-serial converter. A word presented on q is captured on any
// rising edge where qstrobe is high and is shifted out MSB first on qbit,
// one bit per clock, with qbiten marking each valid bit. Both outputs are
// registered, so the first bit of a word is visible in the cycle right after
// the capturing edge.
//
// A strobe always wins. If a strobe arrives mid-word, the current word is
// abandoned and the new word's MSB appears next cycle. If the strobe lands on
// the edge that would otherwise end a word, the new word follows with no gap.
//
// Parameters
//   L        parallel word width in bits (L >= 1)
//
// Ports
//   clk      single clock, all state updates on the rising edge
//   reset    asynchronous active-low reset (0 = reset, 1 = run)
//   q        [L-1:0] parallel word to serialize
//   qstrobe  load request, q captured on every rising edge where it is 1
//   qbit     serial data bit, MSB first, forced to 0 while idle
//   qbiten   serial data valid, 1 for exactly L cycles per whole word
// ----------------------------------------------------------------------------
module serializer #(
    parameter int L = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [L-1:0] q,
    input  logic         qstrobe,
    output logic         qbit,
    output logic         qbiten
);

    // The counter holds the number of bits of the current word that have not
    // yet been retired, counting the one presented on qbit right now. It is L
    // straight after a capture and reaches 1 while the LSB is on the wire.
    localparam int              CW       = $clog2(L + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(L);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [L-1:0]    SR_ZERO  = {L{1'b0}};

    logic [L-1:0]  shift_r;
    logic [CW-1:0] cnt_r;
    logic          qbit_r;
    logic          qbiten_r;

    logic [L-1:0]  shifted_s;
    logic [L-1:0]  shift_nxt_s;
    logic [CW-1:0] cnt_nxt_s;
    logic          qbit_nxt_s;
    logic          qbiten_nxt_s;

    // The register keeps the bit currently on the wire in its MSB; shifting
    // once exposes the next bit. With L=1 the shift yields 0, which is never
    // used because the counter cannot exceed 1 in that configuration.
    assign shifted_s = shift_r << 1;

    // Next-state selection: a strobe reloads, otherwise advance or go idle.
    always_comb begin
        shift_nxt_s  = shift_r;
        cnt_nxt_s    = cnt_r;
        qbit_nxt_s   = 1'b0;
        qbiten_nxt_s = 1'b0;
        if (qstrobe) begin
            // Capture wins over everything, including the final bit of a
            // word in flight, which gives gap-free back-to-back words.
            shift_nxt_s  = q;
            cnt_nxt_s    = CNT_FULL;
            qbit_nxt_s   = q[L-1];
            qbiten_nxt_s = 1'b1;
        end else if (cnt_r > CNT_ONE) begin
            shift_nxt_s  = shifted_s;
            cnt_nxt_s    = cnt_r - CNT_ONE;
            qbit_nxt_s   = shifted_s[L-1];
            qbiten_nxt_s = 1'b1;
        end else begin
            // Last bit retired (or already idle): clear everything so the
            // outputs sit at 0 regardless of q.
            shift_nxt_s  = SR_ZERO;
            cnt_nxt_s    = CNT_ZERO;
            qbit_nxt_s   = 1'b0;
            qbiten_nxt_s = 1'b0;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r  <= SR_ZERO;
            cnt_r    <= CNT_ZERO;
            qbit_r   <= 1'b0;
            qbiten_r <= 1'b0;
        end else begin
            shift_r  <= shift_nxt_s;
            cnt_r    <= cnt_nxt_s;
            qbit_r   <= qbit_nxt_s;
            qbiten_r <= qbiten_nxt_s;
        end
    end

    assign qbit   = qbit_r;
    assign qbiten = qbiten_r;

endmodule

// File: tb/tb_serializer.sv
// ----------------------------------------------------------------------------
// tb_serializer
//
// Directed bench for serializer. One L=8 instance carries most scenarios; a
// second L=1 instance covers the single-bit word. Inputs change on the
// falling edge, outputs are sampled on the falling edge, so every sample sees
// the result of the preceding rising edge.
// ----------------------------------------------------------------------------
module tb_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] q;
    logic       qstrobe;
    logic       qbit;
    logic       qbiten;

    logic [0:0] q1;
    logic       qstrobe1;
    logic       qbit1;
    logic       qbiten1;

    int total;
    int bad;

    serializer #(.L(8)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .q       (q),
        .qstrobe (qstrobe),
        .qbit    (qbit),
        .qbiten  (qbiten)
    );

    serializer #(.L(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .q       (q1),
        .qstrobe (qstrobe1),
        .qbit    (qbit1),
        .qbiten  (qbiten1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset state, strobe ignored during reset, strobe on first edge after.
    task automatic test_reset();
        logic [7:0] w;
        w = 8'b1011_0010;
        reset = 1'b0; q = 8'hFF; qstrobe = 1'b1; q1 = 1'b1; qstrobe1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (qbiten !== 1'b0 || qbit !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
            end
        end
        q = w; reset = 1'b1;
        @(negedge clk);
        qstrobe = 1'b0; q = 8'h00;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (qbiten !== 1'b1 || qbit !== w[7-i]) begin
                bad++;
                $display("FAIL first_edge bit%0d: got en=%b bit=%b want en=1 bit=%b", i, qbiten, qbit, w[7-i]);
            end
            @(negedge clk);
        end
        total++;
        if (qbiten !== 1'b0 || qbit !== 1'b0) begin
            bad++;
            $display("FAIL first_edge_idle: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
        end
    endtask

    // One word, then a 10-cycle idle gap, then the same word again.
    task automatic test_basic_repeat();
        logic [7:0] w;
        w = 8'b0110_1001;
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            q = w; qstrobe = 1'b1;
            @(negedge clk);
            qstrobe = 1'b0;
            for (int i = 0; i < 8; i++) begin
                total++;
                if (qbiten !== 1'b1 || qbit !== w[7-i]) begin
                    bad++;
                    $display("FAIL basic rep%0d bit%0d: got en=%b bit=%b want en=1 bit=%b", rep, i, qbiten, qbit, w[7-i]);
                end
                @(negedge clk);
            end
            for (int g = 0; g < 10; g++) begin
                total++;
                if (qbiten !== 1'b0 || qbit !== 1'b0) begin
                    bad++;
                    $display("FAIL gap rep%0d cyc%0d: got en=%b bit=%b want en=0 bit=0", rep, g, qbiten, qbit);
                end
                if (g < 9) @(negedge clk);
            end
        end
    endtask

    // FF interrupted on its 4th bit by 00: three ones then eight zeros.
    task automatic test_abort();
        logic [10:0] exp_bits;
        exp_bits = 11'b111_0000_0000;
        @(negedge clk);
        q = 8'hFF; qstrobe = 1'b1;
        @(negedge clk);
        qstrobe = 1'b0;
        for (int i = 0; i < 11; i++) begin
            total++;
            if (qbiten !== 1'b1 || qbit !== exp_bits[10-i]) begin
                bad++;
                $display("FAIL abort bit%0d: got en=%b bit=%b want en=1 bit=%b", i, qbiten, qbit, exp_bits[10-i]);
            end
            if (i == 2) begin
                q = 8'h00; qstrobe = 1'b1;
            end else begin
                qstrobe = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (qbiten !== 1'b0 || qbit !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
        end
    endtask

    // A5 followed by 3C on the edge that ends A5: 16 contiguous valid bits.
    task automatic test_back_to_back();
        logic [15:0] exp_bits;
        exp_bits = 16'b1010_0101_0011_1100;
        @(negedge clk);
        q = 8'hA5; qstrobe = 1'b1;
        @(negedge clk);
        qstrobe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (qbiten !== 1'b1 || qbit !== exp_bits[15-i]) begin
                bad++;
                $display("FAIL b2b bit%0d: got en=%b bit=%b want en=1 bit=%b", i, qbiten, qbit, exp_bits[15-i]);
            end
            if (i == 7) begin
                q = 8'h3C; qstrobe = 1'b1;
            end else begin
                qstrobe = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (qbiten !== 1'b0 || qbit !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
        end
    endtask

    // Strobe held for three edges (80, 00, C3): MSBs 1,0 then all of C3.
    task automatic test_hold_strobe();
        logic [9:0] exp_bits;
        exp_bits = 10'b10_1100_0011;
        @(negedge clk);
        q = 8'h80; qstrobe = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (qbiten !== 1'b1 || qbit !== exp_bits[9-i]) begin
                bad++;
                $display("FAIL hold bit%0d: got en=%b bit=%b want en=1 bit=%b", i, qbiten, qbit, exp_bits[9-i]);
            end
            if (i == 0) begin
                q = 8'h00;
            end else if (i == 1) begin
                q = 8'hC3;
            end else begin
                qstrobe = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (qbiten !== 1'b0 || qbit !== 1'b0) begin
            bad++;
            $display("FAIL hold_idle: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
        end
    endtask

    // Asynchronous reset between edges kills the word; nothing after release.
    task automatic test_async_reset();
        @(negedge clk);
        q = 8'hFF; qstrobe = 1'b1;
        @(negedge clk);
        qstrobe = 1'b0;
        @(negedge clk);
        total++;
        if (qbiten !== 1'b1 || qbit !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got en=%b bit=%b want en=1 bit=1", qbiten, qbit);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (qbiten !== 1'b0 || qbit !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (qbiten !== 1'b0 || qbit !== 1'b0) begin
                bad++;
                $display("FAIL post_reset cyc%0d: got en=%b bit=%b want en=0 bit=0", c, qbiten, qbit);
            end
        end
    endtask

    // q wanders while idle and while a word is in flight; only capture counts.
    task automatic test_q_change();
        logic [7:0] w;
        w = 8'h96;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            q = 8'hFF ^ 8'(c * 37);
            total++;
            if (qbiten !== 1'b0 || qbit !== 1'b0) begin
                bad++;
                $display("FAIL idle_q cyc%0d: got en=%b bit=%b want en=0 bit=0", c, qbiten, qbit);
            end
        end
        @(negedge clk);
        q = w; qstrobe = 1'b1;
        @(negedge clk);
        qstrobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q = ~w ^ 8'(i * 11);
            total++;
            if (qbiten !== 1'b1 || qbit !== w[7-i]) begin
                bad++;
                $display("FAIL q_change bit%0d: got en=%b bit=%b want en=1 bit=%b", i, qbiten, qbit, w[7-i]);
            end
            @(negedge clk);
        end
        total++;
        if (qbiten !== 1'b0 || qbit !== 1'b0) begin
            bad++;
            $display("FAIL q_change_idle: got en=%b bit=%b want en=0 bit=0", qbiten, qbit);
        end
    endtask

    // L=1: one valid cycle per word, held strobe gives 1,0,1 contiguously.
    task automatic test_width_one();
        logic [2:0] exp_bits;
        exp_bits = 3'b101;
        @(negedge clk);
        q1 = 1'b1; qstrobe1 = 1'b1;
        @(negedge clk);
        qstrobe1 = 1'b0; q1 = 1'b0;
        total++;
        if (qbiten1 !== 1'b1 || qbit1 !== 1'b1) begin
            bad++;
            $display("FAIL l1_single: got en=%b bit=%b want en=1 bit=1", qbiten1, qbit1);
        end
        @(negedge clk);
        total++;
        if (qbiten1 !== 1'b0 || qbit1 !== 1'b0) begin
            bad++;
            $display("FAIL l1_idle: got en=%b bit=%b want en=0 bit=0", qbiten1, qbit1);
        end
        q1 = 1'b1; qstrobe1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (qbiten1 !== 1'b1 || qbit1 !== exp_bits[2-i]) begin
                bad++;
                $display("FAIL l1_hold bit%0d: got en=%b bit=%b want en=1 bit=%b", i, qbiten1, qbit1, exp_bits[2-i]);
            end
            if (i == 0) begin
                q1 = 1'b0;
            end else if (i == 1) begin
                q1 = 1'b1;
            end else begin
                qstrobe1 = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (qbiten1 !== 1'b0 || qbit1 !== 1'b0) begin
            bad++;
            $display("FAIL l1_hold_idle: got en=%b bit=%b want en=0 bit=0", qbiten1, qbit1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_repeat();
        test_abort();
        test_back_to_back();
        test_hold_strobe();
        test_async_reset();
        test_q_change();
        test_width_one();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
